// File: rtl/melody_memory_game_if.sv
// Bus between the keypad/loader side and the melody game core.
// The game core takes the slave modport.
interface melody_memory_game_if #(
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LIVES  = 3
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned LIV_W = $clog2(LIVES + 1);

    logic                     load_en;
    logic [NOTE_W*DEPTH-1:0]  load_data;
    logic                     start;
    logic                     key_valid;
    logic [NOTE_W-1:0]        key_data;
    logic [NOTE_W-1:0]        tone_out;
    logic [NOTE_W-1:0]        led_out;
    logic                     playing;
    logic                     awaiting_input;
    logic                     miss_pulse;
    logic [LVL_W-1:0]         level;
    logic [LVL_W-1:0]         score;
    logic [LIV_W-1:0]         lives_left;
    logic                     game_over;
    logic                     game_win;

    modport master (
        output load_en, load_data, start, key_valid, key_data,
        input  tone_out, led_out, playing, awaiting_input, miss_pulse,
        input  level, score, lives_left, game_over, game_win
    );

    modport slave (
        input  load_en, load_data, start, key_valid, key_data,
        output tone_out, led_out, playing, awaiting_input, miss_pulse,
        output level, score, lives_left, game_over, game_win
    );
endinterface

// File: rtl/melody_memory_game.sv
// Melody repeat game: plays a growing prefix of a stored melody, then checks the
// player's keypad repetition note by note, tracking lives, score and win/lose.
module melody_memory_game #(
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned START_LEN  = 3,
    parameter int unsigned ON_CYCLES  = 3,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned LIVES      = 3
) (
    input logic                 clk,
    input logic                 reset,
    melody_memory_game_if.slave bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned LIV_W = $clog2(LIVES + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned DUR_W = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        StIdle, StPlayOn, StPlayOff, StInput, StEcho, StWin, StLose
    } state_e;

    state_e            state_q;
    logic [NOTE_W-1:0] notes_q [DEPTH];
    logic              loaded_q;
    logic              hit_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DUR_W-1:0]  dur_q;
    logic [NOTE_W-1:0] tone_q;
    logic              playing_q;
    logic              awaiting_q;
    logic              miss_q;
    logic              over_q;
    logic              win_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  score_q;
    logic [LIV_W-1:0]  lives_q;

    logic             idx_last;
    logic             on_done;
    logic             off_done;
    logic [IDX_W-1:0] idx_next;

    always_comb begin
        idx_last = (LVL_W'(idx_q) == level_q - LVL_W'(1));
        on_done  = (dur_q == DUR_W'(ON_CYCLES - 1));
        off_done = (dur_q == DUR_W'(OFF_CYCLES - 1));
        idx_next = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            for (int k = 0; k < DEPTH; k++) notes_q[k] <= '0;
            loaded_q   <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            dur_q      <= '0;
            tone_q     <= '0;
            playing_q  <= 1'b0;
            awaiting_q <= 1'b0;
            miss_q     <= 1'b0;
            over_q     <= 1'b0;
            win_q      <= 1'b0;
            level_q    <= '0;
            score_q    <= '0;
            lives_q    <= '0;
        end else begin
            miss_q <= 1'b0;
            case (state_q)
                StIdle, StWin, StLose: begin
                    // A load in the same cycle as start takes priority.
                    if (bus.load_en) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            notes_q[k] <= bus.load_data[k*NOTE_W +: NOTE_W];
                        end
                        loaded_q <= 1'b1;
                    end else if (bus.start && loaded_q) begin
                        level_q   <= LVL_W'(START_LEN);
                        score_q   <= '0;
                        lives_q   <= LIV_W'(LIVES);
                        over_q    <= 1'b0;
                        win_q     <= 1'b0;
                        idx_q     <= '0;
                        dur_q     <= '0;
                        tone_q    <= notes_q[0];
                        playing_q <= 1'b1;
                        state_q   <= StPlayOn;
                    end
                end
                StPlayOn: begin
                    if (on_done) begin
                        dur_q   <= '0;
                        tone_q  <= '0;
                        state_q <= StPlayOff;
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                StPlayOff: begin
                    if (off_done) begin
                        dur_q <= '0;
                        if (idx_last) begin
                            idx_q      <= '0;
                            playing_q  <= 1'b0;
                            awaiting_q <= 1'b1;
                            state_q    <= StInput;
                        end else begin
                            idx_q   <= idx_next;
                            tone_q  <= notes_q[idx_next];
                            state_q <= StPlayOn;
                        end
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                StInput: begin
                    if (bus.key_valid) begin
                        hit_q      <= (bus.key_data == notes_q[idx_q]);
                        tone_q     <= bus.key_data;
                        awaiting_q <= 1'b0;
                        dur_q      <= '0;
                        state_q    <= StEcho;
                    end
                end
                StEcho: begin
                    if (on_done) begin
                        dur_q  <= '0;
                        tone_q <= '0;
                        if (hit_q && !idx_last) begin
                            idx_q      <= idx_next;
                            awaiting_q <= 1'b1;
                            state_q    <= StInput;
                        end else if (hit_q) begin
                            idx_q <= '0;
                            if (score_q < LVL_W'(DEPTH)) score_q <= score_q + LVL_W'(1);
                            if (level_q < LVL_W'(DEPTH)) begin
                                level_q   <= level_q + LVL_W'(1);
                                tone_q    <= notes_q[0];
                                playing_q <= 1'b1;
                                state_q   <= StPlayOn;
                            end else begin
                                win_q   <= 1'b1;
                                state_q <= StWin;
                            end
                        end else begin
                            miss_q <= 1'b1;
                            idx_q  <= '0;
                            if (lives_q <= LIV_W'(1)) begin
                                lives_q <= '0;
                                over_q  <= 1'b1;
                                state_q <= StLose;
                            end else begin
                                lives_q   <= lives_q - LIV_W'(1);
                                tone_q    <= notes_q[0];
                                playing_q <= 1'b1;
                                state_q   <= StPlayOn;
                            end
                        end
                    end else begin
                        dur_q <= dur_q + DUR_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tone_out       = tone_q;
    assign bus.led_out        = tone_q;
    assign bus.playing        = playing_q;
    assign bus.awaiting_input = awaiting_q;
    assign bus.miss_pulse     = miss_q;
    assign bus.level          = level_q;
    assign bus.score          = score_q;
    assign bus.lives_left     = lives_q;
    assign bus.game_over      = over_q;
    assign bus.game_win       = win_q;
endmodule

// File: tb/tb_melody_memory_game.sv
// Randomized bench for melody_memory_game: a game-rule model predicts every
// playback/echo cycle, lives, score and end state.
module tb_melody_memory_game;
    localparam int unsigned NOTE_W     = 4;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned START_LEN  = 3;
    localparam int unsigned ON_CYCLES  = 3;
    localparam int unsigned OFF_CYCLES = 2;
    localparam int unsigned LIVES      = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    melody_memory_game_if #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .LIVES(LIVES)) bus ();

    melody_memory_game #(
        .NOTE_W    (NOTE_W),
        .DEPTH     (DEPTH),
        .START_LEN (START_LEN),
        .ON_CYCLES (ON_CYCLES),
        .OFF_CYCLES(OFF_CYCLES),
        .LIVES     (LIVES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the game: stored melody plus level/score/lives.
    int notes [DEPTH];
    int m_level;
    int m_score;
    int m_lives;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrong_key(input int n);
        return (n + 1 + int'($urandom_range(0, (1 << NOTE_W) - 2))) % (1 << NOTE_W);
    endfunction

    task automatic load_melody(input logic [NOTE_W*DEPTH-1:0] data, input bit with_start);
        bus.load_en   = 1'b1;
        bus.load_data = data;
        bus.start     = with_start;
        step();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        for (int k = 0; k < DEPTH; k++) notes[k] = int'(data[k*NOTE_W +: NOTE_W]);
        check_eq("load_idle", int'(bus.playing), 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_level = START_LEN;
        m_score = 0;
        m_lives = LIVES;
    endtask

    // Checks one whole playback from its first PLAY_ON cycle; leaves the bench in INPUT.
    task automatic check_playback(input bit junk);
        int exp;
        for (int k = 0; k < m_level; k++) begin
            for (int c = 0; c < ON_CYCLES + OFF_CYCLES; c++) begin
                exp = (c < ON_CYCLES) ? notes[k] : 0;
                check_eq("play_tone", int'(bus.tone_out), exp);
                check_eq("play_led", int'(bus.led_out), exp);
                check_eq("playing", int'(bus.playing), 1);
                if (k == 0 && c == 0) begin
                    check_eq("level", int'(bus.level), m_level);
                    check_eq("score", int'(bus.score), m_score);
                    check_eq("lives", int'(bus.lives_left), m_lives);
                    check_eq("over_clr", int'(bus.game_over), 0);
                    check_eq("win_clr", int'(bus.game_win), 0);
                    if (junk) begin
                        bus.load_en   = 1'b1;
                        bus.load_data = (NOTE_W*DEPTH)'($urandom);
                        bus.start     = 1'b1;
                    end
                end else if (k == 0 && c == 1) begin
                    check_eq("miss_one_cycle", int'(bus.miss_pulse), 0);
                end
                bus.key_valid = 1'($urandom_range(0, 1));
                bus.key_data  = NOTE_W'($urandom);
                step();
                bus.load_en = 1'b0;
                bus.start   = 1'b0;
            end
        end
        bus.key_valid = 1'b0;
        check_eq("awaiting", int'(bus.awaiting_input), 1);
        check_eq("input_silent", int'(bus.tone_out), 0);
        check_eq("input_not_playing", int'(bus.playing), 0);
    endtask

    task automatic press(input int key);
        bus.key_valid = 1'b1;
        bus.key_data  = NOTE_W'(key);
        step();
        for (int c = 0; c < ON_CYCLES; c++) begin
            check_eq("echo_tone", int'(bus.tone_out), key);
            check_eq("echo_not_awaiting", int'(bus.awaiting_input), 0);
            bus.key_valid = 1'($urandom_range(0, 1));
            bus.key_data  = NOTE_W'($urandom);
            step();
        end
        bus.key_valid = 1'b0;
    endtask

    // result: 0 = next playback follows, 1 = won, 2 = lost.
    task automatic play_round(input int miss_at, output int result);
        result = 0;
        for (int i = 0; i < m_level; i++) begin
            press((i == miss_at) ? wrong_key(notes[i]) : notes[i]);
            if (i == miss_at) begin
                m_lives--;
                check_eq("miss_pulse", int'(bus.miss_pulse), 1);
                check_eq("lives_after_miss", int'(bus.lives_left), m_lives);
                if (m_lives == 0) begin
                    check_eq("game_over", int'(bus.game_over), 1);
                    check_eq("lose_silent", int'(bus.tone_out), 0);
                    check_eq("lose_not_awaiting", int'(bus.awaiting_input), 0);
                    check_eq("lose_not_playing", int'(bus.playing), 0);
                    result = 2;
                end
                return;
            end
            check_eq("no_miss", int'(bus.miss_pulse), 0);
            if (i < m_level - 1) begin
                check_eq("next_awaiting", int'(bus.awaiting_input), 1);
                check_eq("next_silent", int'(bus.tone_out), 0);
            end
        end
        if (m_score < DEPTH) m_score++;
        check_eq("score_cleared", int'(bus.score), m_score);
        if (m_level == DEPTH) begin
            check_eq("game_win", int'(bus.game_win), 1);
            check_eq("win_silent", int'(bus.tone_out), 0);
            check_eq("win_level", int'(bus.level), DEPTH);
            result = 1;
        end else begin
            m_level++;
        end
    endtask

    task automatic run_game(input int miss_pct, output int result);
        int miss_at;
        result = 0;
        do_start();
        for (int r = 0; r < 32; r++) begin
            check_playback(1'($urandom_range(0, 1)));
            miss_at = (int'($urandom_range(0, 99)) < miss_pct) ?
                      int'($urandom_range(0, m_level - 1)) : DEPTH;
            play_round(miss_at, result);
            if (result != 0) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int res;
        reset         = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = '0;
        step();
        step();
        reset = 1'b0;
        check_eq("rst_tone", int'(bus.tone_out), 0);
        check_eq("rst_level", int'(bus.level), 0);
        check_eq("rst_lives", int'(bus.lives_left), 0);
        check_eq("rst_playing", int'(bus.playing), 0);
        check_eq("rst_over", int'(bus.game_over), 0);

        // Fixed melody 1..8: level-up, then misses down to game over.
        load_melody(32'h8765_4321, 1'b0);
        do_start();
        check_playback(1'b0);
        play_round(DEPTH, res);
        check_playback(1'b0);
        play_round(1, res);
        check_playback(1'b1);
        play_round(0, res);
        check_playback(1'b1);
        play_round(2, res);
        check_eq("lost", res, 2);
        for (int c = 0; c < 6; c++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = NOTE_W'(notes[0]);
            step();
            check_eq("lose_key_ignored", int'(bus.tone_out), 0);
            check_eq("lose_held", int'(bus.game_over), 1);
            check_eq("lose_pulse_low", int'(bus.miss_pulse), 0);
        end
        bus.key_valid = 1'b0;

        // Flawless game to the win state, then load a new melody while won.
        run_game(0, res);
        check_eq("won", res, 1);
        check_eq("win_score", int'(bus.score), DEPTH - START_LEN + 1);
        load_melody((NOTE_W*DEPTH)'($urandom), 1'b0);
        check_eq("win_held", int'(bus.game_win), 1);

        for (int g = 0; g < 5; g++) begin
            run_game(35, res);
            if (g == 2) load_melody((NOTE_W*DEPTH)'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of playback.
        do_start();
        step();
        #2 reset = 1'b1;
        #1;
        check_eq("async_tone", int'(bus.tone_out), 0);
        check_eq("async_playing", int'(bus.playing), 0);
        check_eq("async_level", int'(bus.level), 0);
        check_eq("async_lives", int'(bus.lives_left), 0);
        #2 reset = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("unloaded_idle", int'(bus.playing), 0);
            check_eq("unloaded_level", int'(bus.level), 0);
            step();
        end
        load_melody((NOTE_W*DEPTH)'($urandom), 1'b1);
        check_eq("load_start_level", int'(bus.level), 0);
        step();
        check_eq("load_start_idle", int'(bus.playing), 0);
        do_start();
        check_playback(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/melody_memory_game.md
Name: melody_memory_game

Overview:
Parametrised successor to the keypad melody-repeat game core. It stores a loaded melody of DEPTH notes and plays a growing prefix to the piezo and LED drivers. It then checks the player's keypad repetition note by note. Compared with the previous generation it adds configurable note width and depth, exact on/off note timing, a lives counter, a score, and explicit win/lose end states. It sits between the keypad decoder/loader and the piezo/LED drivers.

Parameters:
NOTE_W, 4, bits per note/key code
DEPTH, 8, max melody length in notes
START_LEN, 3, prefix length at game start (1..DEPTH)
ON_CYCLES, 3, clocks a note sounds (>=1)
OFF_CYCLES, 2, clocks of silence after each note (>=1)
LIVES, 3, misses allowed before game over (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_en  in  1  load melody strobe
load_data  in  NOTE_W*DEPTH  melody; note k = load_data[k*NOTE_W +: NOTE_W]
start  in  1  start/restart game strobe
key_valid  in  1  one-cycle keypad strobe
key_data  in  NOTE_W  key code, valid with key_valid
tone_out  out  NOTE_W  piezo note code, 0 = silent
led_out  out  NOTE_W  LED code, always equals tone_out
playing  out  1  melody playback in progress
awaiting_input  out  1  high in INPUT state
miss_pulse  out  1  one-cycle pulse on wrong key
level  out  clog2(DEPTH+1)  current prefix length
score  out  clog2(DEPTH+1)  levels cleared
lives_left  out  clog2(LIVES+1)  remaining lives
game_over  out  1  lost; held until start/reset
game_win  out  1  won; held until start/reset

Behaviour:
- Reset (async) clears all outputs, the melody and the loaded flag. FSM goes to IDLE.
- All outputs are registered.
- FSM states: IDLE, PLAY_ON, PLAY_OFF, INPUT, ECHO, WIN, LOSE. Counters: idx (note index), dur (clocks in current phase).
- load_en is accepted only in IDLE/WIN/LOSE. It latches load_data and sets loaded. It is ignored in other states.
- start is accepted only in IDLE/WIN/LOSE with loaded=1 (including the loaded set on an earlier cycle).
- If load_en and start are asserted in the same cycle, load wins and start is ignored.
- On start: level=START_LEN, score=0, lives_left=LIVES, game_over=game_win=0, idx=0. Same edge enters PLAY_ON with tone_out=note[0].
- PLAY_ON: tone_out=note[idx] for exactly ON_CYCLES clocks, then PLAY_OFF.
- PLAY_OFF: tone_out=0 for exactly OFF_CYCLES clocks.
  - If idx==level-1: go to INPUT with idx=0.
  - Otherwise: idx+1, back to PLAY_ON.
- playing=1 in PLAY_ON and PLAY_OFF.
- key_valid is ignored (not queued) in every state except INPUT.
- INPUT, on key_valid: latch hit=(key_data==note[idx]), tone_out=key_data, enter ECHO for ON_CYCLES clocks. Further keys are ignored during ECHO.
- ECHO end (tone_out=0), taking exactly one of these:
  - hit and idx<level-1: idx+1, go to INPUT.
  - hit and idx==level-1 and level<DEPTH: score+1, level+1, idx=0, go to PLAY_ON.
  - hit and idx==level-1 and level==DEPTH: score+1, game_win=1, go to WIN.
  - miss: miss_pulse for that one cycle, lives_left-1, idx=0. If lives_left becomes 0: game_over=1, go to LOSE. Otherwise replay the same level from PLAY_ON.
- WIN/LOSE: tone_out=0, flags held. start restarts the game using the stored melody.
- score saturates at DEPTH. lives_left never wraps below 0.
- Reset mid-operation aborts immediately. A subsequent start without a new load is ignored.

Test Plan:
- Defaults; load 0x87654321; start -> next edge tone_out=1 for 3 clk, 0 for 2, then 2, then 3 (same timing). awaiting_input=1, level=3, lives_left=3.
- In INPUT, keys 1,2,3 (spaced by >ON_CYCLES) -> each echoed 3 clk. After last echo: score=1, level=4, replay 1,2,3,4.
- At level 3, keys 1,5 -> miss_pulse one cycle after echo of 5, lives_left=2, replay 1,2,3. Extra key_valid during replay -> no effect.
- Three misses -> game_over=1, lives_left=0, tone_out=0, keys ignored. start -> fresh game with level=3, lives=3.
- Clear all levels through level 8 -> game_win=1, score=6, level=8. load_en in WIN accepted; load_en during PLAY_ON ignored.
- Reset asserted mid PLAY_ON -> all outputs 0 without waiting for a clock edge. start alone afterwards -> stays IDLE. load_en+start same cycle -> load only, IDLE.
